// File: rtl/mem_ctrl.sv
// Word-wide memory controller that serves a load/store port and an instruction-fetch port
// over a byte-wide RAM. Each port has one pending slot; the load/store port has fixed priority.
// A word access is four byte beats (little-endian), with done pulsing four edges after the
// request-sampling edge. The word is four bytes, so DATA_WIDTH is expected to be 32.
module mem_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ls_valid,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_src,
  output logic                  ls_done,
  output logic [DATA_WIDTH-1:0] ls_data,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e state_q, state_d;

  // Pending slots
  logic                  ls_pend_q, ls_we_q;
  logic [ADDR_WIDTH-1:0] ls_addr_q;
  logic [DATA_WIDTH-1:0] ls_src_q;
  logic                  if_pend_q;
  logic [ADDR_WIDTH-1:0] if_addr_q;

  // Datapath registers and their next values
  logic [1:0]            cnt_q, cnt_d;
  logic                  serve_ls_q, serve_ls_d;
  logic [23:0]           wdata_q, wdata_d;
  logic [23:0]           rd_buf_q, rd_buf_d;
  logic                  ls_done_d, if_done_d, ram_we_d;
  logic [DATA_WIDTH-1:0] ls_data_d, if_data_d;
  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic [7:0]            ram_dout_d;

  // A request pulsed into an empty slot is visible immediately so IDLE can start it this edge
  logic                  ls_req, ls_cur_we, if_req, last_beat;
  logic [ADDR_WIDTH-1:0] ls_cur_addr, if_cur_addr;
  logic [DATA_WIDTH-1:0] ls_cur_src;

  assign ls_req      = ls_pend_q || ls_valid;
  assign ls_cur_we   = ls_pend_q ? ls_we_q : ls_we;
  assign ls_cur_addr = ls_pend_q ? ls_addr_q : ls_addr;
  assign ls_cur_src  = ls_pend_q ? ls_src_q : ls_src;
  assign if_req      = if_pend_q || if_valid;
  assign if_cur_addr = if_pend_q ? if_addr_q : if_addr;
  assign last_beat   = (cnt_q == 2'd3);
  assign busy        = (state_q != StIdle);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state: ls wins over if; an access ends after its fourth beat
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ls_req)      state_d = ls_cur_we ? StWrite : StRead;
        else if (if_req) state_d = StRead;
      end
      StRead, StWrite: if (last_beat) state_d = StIdle;
      default:         state_d = StIdle;
    endcase
  end

  // Output/datapath next values; RAM address and data hold while idle
  always_comb begin
    cnt_d      = cnt_q;
    serve_ls_d = serve_ls_q;
    wdata_d    = wdata_q;
    rd_buf_d   = rd_buf_q;
    ls_data_d  = ls_data;
    if_data_d  = if_data;
    ram_addr_d = ram_addr;
    ram_dout_d = ram_dout;
    ram_we_d   = 1'b0;
    ls_done_d  = 1'b0;
    if_done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = 2'd0;
        if (ls_req) begin
          serve_ls_d = 1'b1;
          ram_addr_d = ls_cur_addr;
          if (ls_cur_we) begin
            ram_we_d   = 1'b1;
            ram_dout_d = ls_cur_src[7:0];
            wdata_d    = ls_cur_src[31:8];
          end
        end else if (if_req) begin
          serve_ls_d = 1'b0;
          ram_addr_d = if_cur_addr;
        end
      end
      StRead: begin
        // Bytes arrive low first; shifting in from the top leaves byte0 at bits 7:0
        rd_buf_d = {ram_din, rd_buf_q[23:8]};
        if (last_beat) begin
          if (serve_ls_q) begin
            ls_data_d = DATA_WIDTH'({ram_din, rd_buf_q});
            ls_done_d = 1'b1;
          end else begin
            if_data_d = DATA_WIDTH'({ram_din, rd_buf_q});
            if_done_d = 1'b1;
          end
        end else begin
          ram_addr_d = ram_addr + ADDR_WIDTH'(1);
          cnt_d      = cnt_q + 2'd1;
        end
      end
      StWrite: begin
        if (last_beat) begin
          ls_done_d = 1'b1;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = ram_addr + ADDR_WIDTH'(1);
          ram_dout_d = wdata_q[7:0];
          wdata_d    = {8'h00, wdata_q[23:8]};
          cnt_d      = cnt_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= 2'd0;
      serve_ls_q <= 1'b0;
      wdata_q    <= '0;
      rd_buf_q   <= '0;
      ls_done    <= 1'b0;
      if_done    <= 1'b0;
      ls_data    <= '0;
      if_data    <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_dout   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      serve_ls_q <= serve_ls_d;
      wdata_q    <= wdata_d;
      rd_buf_q   <= rd_buf_d;
      ls_done    <= ls_done_d;
      if_done    <= if_done_d;
      ls_data    <= ls_data_d;
      if_data    <= if_data_d;
      ram_we     <= ram_we_d;
      ram_addr   <= ram_addr_d;
      ram_dout   <= ram_dout_d;
    end
  end

  // Slots: occupied from the request pulse until that port's done; pulses into a full slot drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ls_pend_q <= 1'b0;
      ls_we_q   <= 1'b0;
      ls_addr_q <= '0;
      ls_src_q  <= '0;
      if_pend_q <= 1'b0;
      if_addr_q <= '0;
    end else begin
      if (ls_done_d) begin
        ls_pend_q <= 1'b0;
      end else if (ls_valid && !ls_pend_q) begin
        ls_pend_q <= 1'b1;
        ls_we_q   <= ls_we;
        ls_addr_q <= ls_addr;
        ls_src_q  <= ls_src;
      end
      if (if_done_d) begin
        if_pend_q <= 1'b0;
      end else if (if_valid && !if_pend_q) begin
        if_pend_q <= 1'b1;
        if_addr_q <= if_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: drivers push expected responses, a monitor pops on done.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ls_valid = 1'b0, ls_we = 1'b0;
  logic [31:0] ls_addr = '0, ls_src = '0;
  logic        ls_done;
  logic [31:0] ls_data;
  logic        if_valid = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout, ram_din;
  logic        busy;

  mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ls_valid(ls_valid), .ls_we(ls_we), .ls_addr(ls_addr), .ls_src(ls_src),
    .ls_done(ls_done), .ls_data(ls_data),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Byte RAM: write on the edge, read data is simply the byte at the presented address
  logic [7:0] ram [0:65535];
  logic [7:0] ref_mem [0:65535];
  always @(posedge clk) if (ram_we) ram[ram_addr[15:0]] <= ram_dout;
  always_comb ram_din = ram[ram_addr[15:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [31:0] data; int exp_cyc;} exp_t;
  exp_t ls_q[$];
  exp_t if_q[$];
  int   checks = 0;
  int   errors = 0;
  logic ls_busy_tb = 1'b0, if_busy_tb = 1'b0;
  logic [31:0] model_ls_data = '0;
  logic [31:0] mon_ls_hold = '0, mon_if_hold = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1; a2 = a + 32'd2; a3 = a + 32'd3;
    return {ref_mem[a3[15:0]], ref_mem[a2[15:0]], ref_mem[a1[15:0]], ref_mem[a[15:0]]};
  endfunction

  task automatic ls_issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input int lat);
    exp_t e;
    logic [31:0] ak;
    @(negedge clk);
    ls_valid = 1'b1; ls_we = we; ls_addr = a; ls_src = d;
    ls_busy_tb = 1'b1;
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        ak = a + 32'(k);
        ref_mem[ak[15:0]] = d[8*k +: 8];
      end
    end else begin
      model_ls_data = ref_word(a);
    end
    e.data = model_ls_data;
    @(negedge clk);
    ls_valid = 1'b0;
    e.exp_cyc = (lat < 0) ? -1 : cyc + lat;
    ls_q.push_back(e);
  endtask

  task automatic if_issue(input logic [31:0] a, input int lat);
    exp_t e;
    @(negedge clk);
    if_valid = 1'b1; if_addr = a;
    if_busy_tb = 1'b1;
    e.data = ref_word(a);
    @(negedge clk);
    if_valid = 1'b0;
    e.exp_cyc = (lat < 0) ? -1 : cyc + lat;
    if_q.push_back(e);
  endtask

  task automatic wait_ls();
    int n = 0;
    while (ls_busy_tb && n < 80) begin @(negedge clk); n++; end
    if (ls_busy_tb) begin
      chk("ls_timeout", 1, 0);
      ls_busy_tb = 1'b0;
      ls_q.delete();
    end
  endtask

  task automatic wait_if();
    int n = 0;
    while (if_busy_tb && n < 80) begin @(negedge clk); n++; end
    if (if_busy_tb) begin
      chk("if_timeout", 1, 0);
      if_busy_tb = 1'b0;
      if_q.delete();
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ls_done"}, 64'(ls_done), 0);
    chk({tag, "_if_done"}, 64'(if_done), 0);
    chk({tag, "_ls_data"}, 64'(ls_data), 0);
    chk({tag, "_if_data"}, 64'(if_data), 0);
    chk({tag, "_ram_we"}, 64'(ram_we), 0);
    chk({tag, "_ram_addr"}, 64'(ram_addr), 0);
    chk({tag, "_ram_dout"}, 64'(ram_dout), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
  endtask

  // Monitor: pops the scoreboard on each done and checks held data between completions
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      mon_ls_hold = '0;
      mon_if_hold = '0;
    end else begin
      chk("done_overlap", 64'(ls_done && if_done), 0);
      if (ls_done) begin
        if (ls_q.size() == 0) begin
          chk("ls_unexpected_done", 1, 0);
        end else begin
          e = ls_q.pop_front();
          ls_busy_tb = 1'b0;
          chk("ls_data", 64'(ls_data), 64'(e.data));
          if (e.exp_cyc >= 0) chk("ls_latency", 64'(cyc), 64'(e.exp_cyc));
          mon_ls_hold = e.data;
        end
      end else begin
        chk("ls_data_hold", 64'(ls_data), 64'(mon_ls_hold));
      end
      if (if_done) begin
        if (if_q.size() == 0) begin
          chk("if_unexpected_done", 1, 0);
        end else begin
          e = if_q.pop_front();
          if_busy_tb = 1'b0;
          chk("if_data", 64'(if_data), 64'(e.data));
          if (e.exp_cyc >= 0) chk("if_latency", 64'(cyc), 64'(e.exp_cyc));
          mon_if_hold = e.data;
        end
      end else begin
        chk("if_data_hold", 64'(if_data), 64'(mon_if_hold));
      end
      if (!busy) chk("idle_ram_we", 64'(ram_we), 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, a;
    logic [15:0] idx;
    logic [7:0]  old2, old3;
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'(i * 37 + 11);
      ref_mem[i] = 8'(i * 37 + 11);
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b1;

    // Store then load at 0x100, exact 4-edge latency, accepted on first edge after reset
    ls_issue(1'b1, 32'h100, 32'hDEADBEEF, 4);
    wait_ls();
    chk("ram_100", 64'(ram[16'h100]), 64'hEF);
    chk("ram_101", 64'(ram[16'h101]), 64'hBE);
    chk("ram_102", 64'(ram[16'h102]), 64'hAD);
    chk("ram_103", 64'(ram[16'h103]), 64'hDE);
    ls_issue(1'b0, 32'h100, 32'h0, 4);
    wait_ls();
    repeat (3) @(negedge clk);

    // Simultaneous ls and if: fetch starts at E5, done at E9
    fork
      ls_issue(1'b0, 32'h104, 32'h0, 4);
      if_issue(32'h4000, 9);
    join
    wait_ls();
    wait_if();
    repeat (2) @(negedge clk);

    // Fetch pulsed while a store is busy
    fork
      ls_issue(1'b1, 32'h108, 32'hCAFE1234, 4);
      begin
        repeat (2) @(negedge clk);
        if_issue(32'h4010, 7);
      end
    join
    wait_ls();
    wait_if();
    repeat (2) @(negedge clk);

    // Address wrap
    ls_issue(1'b0, 32'hFFFFFFFF, 32'h0, 4);
    chk("wrap_addr0", 64'(ram_addr), 64'hFFFFFFFF);
    @(negedge clk); chk("wrap_addr1", 64'(ram_addr), 64'h0);
    @(negedge clk); chk("wrap_addr2", 64'(ram_addr), 64'h1);
    @(negedge clk); chk("wrap_addr3", 64'(ram_addr), 64'h2);
    wait_ls();
    repeat (2) @(negedge clk);

    // Reset asserted just after E2 of a store
    idx  = 16'h120;
    old2 = ref_mem[idx + 16'd2];
    old3 = ref_mem[idx + 16'd3];
    d    = $urandom;
    ls_issue(1'b1, 32'h120, d, 4);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk_zero_outputs("midrst");
    ls_q.delete();
    ls_busy_tb = 1'b0;
    model_ls_data = '0;
    ref_mem[idx + 16'd2] = old2;
    ref_mem[idx + 16'd3] = old3;
    repeat (3) @(negedge clk);
    chk("midrst_byte0", 64'(ram[idx]), 64'(d[7:0]));
    chk("midrst_byte2", 64'(ram[idx + 16'd2]), 64'(old2));
    chk("midrst_byte3", 64'(ram[idx + 16'd3]), 64'(old3));
    rst = 1'b1;
    ls_issue(1'b1, 32'h120, 32'h01234567, 4);
    wait_ls();
    ls_issue(1'b0, 32'h120, 32'h0, 4);
    wait_ls();

    // Randomized traffic on both ports
    fork
      for (int i = 0; i < 50; i++) begin
        logic        w;
        logic [31:0] ra, rd;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        w  = 1'($urandom_range(0, 1));
        ra = 32'h100 + 32'($urandom_range(0, 60));
        rd = $urandom;
        ls_issue(w, ra, rd, -1);
        wait_ls();
      end
      for (int j = 0; j < 50; j++) begin
        logic [31:0] fa;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        fa = 32'h4000 + 32'($urandom_range(0, 252));
        if_issue(fa, -1);
        wait_if();
      end
    join
    repeat (6) @(negedge clk);
    a = 32'(ls_q.size() + if_q.size());
    chk("scoreboard_empty", 64'(a), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
